// File: rtl/touch_i2c_target.sv
// I2C target for the touch bus: filtered START/STOP/bit decode, address match,
// byte register bank with auto-incrementing pointer. Optional clock stretch: TOUCH_I2C_TGT_STRETCH_EN.
module touch_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter int         NUM_REGS = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    output logic                        scl_oe,
    input  logic                        loc_wr,
    input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
    input  logic [7:0]                  loc_wdata,
    output logic                        bus_wr,
    output logic [$clog2(NUM_REGS)-1:0] bus_waddr,
    output logic [7:0]                  bus_wdata,
    output logic                        busy
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int FW = $clog2(FILT_LEN) + 1;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RACK      = 4'd8;
    localparam logic [3:0] IGNORE    = 4'd9;

    // Index 1 carries SCL, index 0 carries SDA through sync and filter.
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] fcnt [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync1  <= {scl_in, sda_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c, sample;
    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_rise = filt[1] & ~filt_d[1];
    assign scl_fall = ~filt[1] & filt_d[1];
    assign start_c  = ~filt[0] & filt_d[0] & scl_f;
    assign stop_c   = filt[0] & ~filt_d[0] & scl_f;
    // A rise while we still hold SCL low is not a real clock.
    assign sample   = scl_rise & ~scl_oe;

    logic [3:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          rw;
    logic [AW-1:0] ptr, ptr_inc;
    logic [7:0]    bank [NUM_REGS];
    logic [7:0]    next_byte;

    assign ptr_inc   = ptr + 1'b1;
    assign next_byte = {shreg[6:0], sda_f};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            bus_wr    <= 1'b0;
            bus_waddr <= '0;
            bus_wdata <= '0;
            // NOTE: the bank must read back as zero after reset, so it is flops, not RAM.
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else begin
            bus_wr <= 1'b0;
            // NOTE: the bus write below comes later in the block, so it wins on a collision.
            if (loc_wr) bank[loc_addr] <= loc_wdata;

            if (start_c) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_c) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (sample) begin
                case (state)
                    ADDR: begin
                        shreg   <= next_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rw    <= sda_f;
                            state <= (shreg[6:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= '0;
                        if (rw) begin
                            shreg <= bank[ptr];
                            state <= RDATA;
                        end else begin
                            state <= PTR;
                        end
                    end
                    PTR: begin
                        shreg   <= next_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            ptr   <= next_byte[AW-1:0];
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        bit_cnt <= '0;
                        state   <= WDATA;
                    end
                    WDATA: begin
                        shreg   <= next_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            bank[ptr] <= next_byte;
                            bus_wr    <= 1'b1;
                            bus_waddr <= ptr;
                            bus_wdata <= next_byte;
                            ptr       <= ptr_inc;
                            state     <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= RACK;
                    end
                    RACK: begin
                        ptr     <= ptr_inc;
                        bit_cnt <= '0;
                        if (!sda_f) begin
                            shreg <= bank[ptr_inc];
                            state <= RDATA;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe <= 1'b1;
                    RDATA:                        sda_oe <= ~shreg[7];
                    default:                      sda_oe <= 1'b0;
                endcase
            end
        end
    end

`ifdef TOUCH_I2C_TGT_STRETCH_EN
    logic       ack_pending;
    logic [3:0] stretch_cnt;

    // Hold SCL low for 16 cycles after the falling edge that ends each ACK/NACK bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_oe      <= 1'b0;
            ack_pending <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            if (start_c || stop_c) begin
                ack_pending <= 1'b0;
            end else if (sample && (state inside {ADDR_ACK, PTR_ACK, WDATA_ACK, RACK})) begin
                ack_pending <= 1'b1;
            end else if (scl_fall && ack_pending) begin
                ack_pending <= 1'b0;
                scl_oe      <= 1'b1;
                stretch_cnt <= 4'd15;
            end
            if (scl_oe) begin
                if (stretch_cnt == 4'd0) scl_oe <= 1'b0;
                else                     stretch_cnt <= stretch_cnt - 1'b1;
            end
        end
    end
`else
    assign scl_oe = 1'b0;
`endif

endmodule

// File: tb/tb_touch_i2c_target.sv
// Directed bench for touch_i2c_target: a bit-banged master on a wired-AND bus,
// with expected ACKs, read bytes and bus writes queued as stimulus is driven.
module tb_touch_i2c_target;
    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sda_oe, scl_oe;
    logic       loc_wr;
    logic [2:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       bus_wr;
    logic [2:0] bus_waddr;
    logic [7:0] bus_wdata;
    logic       busy;

    assign scl_bus = m_scl & ~scl_oe;
    assign sda_bus = m_sda & ~sda_oe;

    touch_i2c_target dut (
        .clk(clk), .reset(reset), .scl_in(scl_bus), .sda_in(sda_bus),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .loc_wr(loc_wr), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .bus_wr(bus_wr), .bus_waddr(bus_waddr),
        .bus_wdata(bus_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb_q [$];
    logic [31:0] bw_q [$];
    bit          oe_seen = 1'b0;
    bit          scl_oe_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] e);
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
        end else begin
            check(tag, obs, sb_q.pop_front());
        end
    endtask

    // Bus-write monitor pops its own expectation queue.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (scl_oe) scl_oe_seen = 1'b1;
        if (bus_wr) begin
            if (bw_q.size() == 0) begin
                miscompares++;
                $error("FAIL bus_wr: unexpected pulse addr %0h data %0h", bus_waddr, bus_wdata);
            end else begin
                check("bus_wr", {21'd0, bus_waddr, bus_wdata}, bw_q.pop_front());
            end
        end
    end

`ifdef TOUCH_I2C_TGT_STRETCH_EN
    int run = 0;
    always @(negedge clk) begin
        if (scl_oe) run++;
        else if (run != 0) begin
            check("stretch_len", run, 16);
            run = 0;
        end
    end
`endif

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic s);
        int t;
        m_sda = b;
        wait_cyc(Q);
        m_scl = 1'b1;
        t = 0;
        while (scl_bus !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            miscompares++;
            $error("FAIL scl_release: SCL still low after %0d cycles", t);
        end
        wait_cyc(Q / 2);
        if (glitch) begin
            m_scl = 1'b0;
            wait_cyc(2);
            m_scl = 1'b1;
        end
        s = sda_bus;
        wait_cyc(Q / 2);
        m_scl = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b1; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_idx, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], i == glitch_idx, s);
        bus_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        bus_bit(nack, 1'b0, s);
    endtask

    task automatic wr_expect(input string tag, input logic [7:0] d, input logic exp_ack);
        logic ack;
        sb_push({31'd0, exp_ack});
        write_byte(d, -1, ack);
        sb_check(tag, {31'd0, ack});
    endtask

    task automatic rd_expect(input string tag, input logic nack, input logic [7:0] exp);
        logic [7:0] d;
        sb_push({24'd0, exp});
        read_byte(nack, d);
        sb_check(tag, {24'd0, d});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        logic ack;
        logic [7:0] a70;
        // NOTE: inputs are driven with blocking assignments on the falling edge, away from the sampling edge.
        reset = 1'b1; loc_wr = 1'b0; loc_addr = '0; loc_wdata = '0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);
        sb_push(0); sb_check("rst_sda_oe", {31'd0, sda_oe});
        sb_push(0); sb_check("rst_scl_oe", {31'd0, scl_oe});
        sb_push(0); sb_check("rst_bus_wr", {31'd0, bus_wr});
        sb_push(0); sb_check("rst_busy",   {31'd0, busy});

        // Write ptr 2, data A5 5A.
        start_cond();
        sb_push(1); sb_check("t1_busy", {31'd0, busy});
        wr_expect("t1_addr_ack", 8'h70, 1'b1);
        wr_expect("t1_ptr_ack",  8'h02, 1'b1);
        bw_q.push_back({21'd0, 3'd2, 8'hA5});
        wr_expect("t1_d0_ack",   8'hA5, 1'b1);
        bw_q.push_back({21'd0, 3'd3, 8'h5A});
        wr_expect("t1_d1_ack",   8'h5A, 1'b1);
        stop_cond();
        wait_cyc(8);
        sb_push(0); sb_check("t1_busy_after_stop", {31'd0, busy});
        check("t1_bw_drained", bw_q.size(), 0);

        // Wrong address 0x39: no drive at all.
        oe_seen = 1'b0;
        start_cond();
        wr_expect("t3_addr_nack", 8'h72, 1'b0);
        wr_expect("t3_data_nack", 8'hFF, 1'b0);
        stop_cond();
        wait_cyc(8);
        sb_push(0); sb_check("t3_oe_seen", {31'd0, oe_seen});

        // Read back bank[2..3] through repeated START.
        start_cond();
        wr_expect("rb_addr_ack", 8'h70, 1'b1);
        wr_expect("rb_ptr_ack",  8'h02, 1'b1);
        start_cond();
        wr_expect("rb_raddr_ack", 8'h71, 1'b1);
        rd_expect("rb_bank2", 1'b0, 8'hA5);
        rd_expect("rb_bank3", 1'b1, 8'h5A);
        stop_cond();

        // STOP after 4 bits of a data byte: partial byte discarded.
        start_cond();
        wr_expect("t4_addr_ack", 8'h70, 1'b1);
        wr_expect("t4_ptr_ack",  8'h04, 1'b1);
        bus_bit(1'b1, 1'b0, s); bus_bit(1'b1, 1'b0, s);
        bus_bit(1'b1, 1'b0, s); bus_bit(1'b0, 1'b0, s);
        stop_cond();
        wait_cyc(8);
        sb_push(0); sb_check("t4_sda_oe", {31'd0, sda_oe});
        sb_push(0); sb_check("t4_busy",   {31'd0, busy});

        // SCL glitch of FILT_LEN-1 cycles during a data bit.
        start_cond();
        wr_expect("t5_addr_ack", 8'h70, 1'b1);
        wr_expect("t5_ptr_ack",  8'h05, 1'b1);
        bw_q.push_back({21'd0, 3'd5, 8'hC3});
        sb_push(1);
        write_byte(8'hC3, 4, ack);
        sb_check("t5_glitch_ack", {31'd0, ack});
        stop_cond();
        start_cond();
        wr_expect("t5_rb_addr_ack", 8'h70, 1'b1);
        wr_expect("t5_rb_ptr_ack",  8'h04, 1'b1);
        start_cond();
        wr_expect("t5_rb_raddr_ack", 8'h71, 1'b1);
        rd_expect("t4_bank4_untouched", 1'b0, 8'h00);
        rd_expect("t5_bank5",           1'b1, 8'hC3);
        stop_cond();

        // Local load, then a wrapping 3-byte read from ptr 6.
        for (int i = 0; i < 8; i++) begin
            loc_wr = 1'b1; loc_addr = 3'(i); loc_wdata = 8'h10 + 8'(i);
            wait_cyc(1);
        end
        loc_wr = 1'b0;
        start_cond();
        wr_expect("t2_addr_ack", 8'h70, 1'b1);
        wr_expect("t2_ptr_ack",  8'h06, 1'b1);
        start_cond();
        wr_expect("t2_raddr_ack", 8'h71, 1'b1);
        rd_expect("t2_rd0", 1'b0, 8'h16);
        rd_expect("t2_rd1", 1'b0, 8'h17);
        rd_expect("t2_rd2_wrap", 1'b1, 8'h10);
        stop_cond();
        // Pointer persisted at 1.
        start_cond();
        wr_expect("t2_ptr_addr_ack", 8'h71, 1'b1);
        rd_expect("t2_final_ptr", 1'b1, 8'h11);
        stop_cond();

        // Reset while the target drives the address ACK.
        a70 = 8'h70;
        start_cond();
        for (int i = 7; i >= 0; i--) bus_bit(a70[i], 1'b0, s);
        sb_push(1); sb_check("rst_mid_ack_drive", {31'd0, sda_oe});
        reset = 1'b1;
        wait_cyc(1);
        sb_push(0); sb_check("rst_mid_sda_oe", {31'd0, sda_oe});
        sb_push(0); sb_check("rst_mid_busy",   {31'd0, busy});
        reset = 1'b0;
        stop_cond();
        start_cond();
        wr_expect("post_rst_addr_ack", 8'h71, 1'b1);
        rd_expect("post_rst_bank0", 1'b1, 8'h00);
        stop_cond();
        wait_cyc(8);

        check("bw_queue_drained", bw_q.size(), 0);
`ifdef TOUCH_I2C_TGT_STRETCH_EN
        check("stretch_seen", {31'd0, scl_oe_seen}, 1);
`else
        check("scl_oe_never", {31'd0, scl_oe_seen}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
